// File: rtl/shot_pool.sv
// shot_pool: fixed pool of projectile slots sharing one spawn point.
//   Each slot moves SHOT_VELOCITY px per frame tick (up or down per DIR_UP),
//   retires at the play-field edge or on a hit, and is drawn as a
//   SHOT_WIDTH x SHOT_HEIGHT box. Spawns are rate-limited by a frame cooldown.
// Ports:
//   s_clk, rst_n       system clock, async active-low reset
//   clk_0              one-cycle frame tick
//   pause              freeze every register
//   fire               spawn request (held or pulsed between ticks)
//   orig_x, orig_y     spawn reference point
//   pixel_x, pixel_y   render coordinate
//   hit_vec            per-slot clear
//   fire_ack           one-cycle pulse on a spawn
//   active_vec         slot occupancy, active_count its popcount
//   shot_x_flat/_y_flat  per-slot left x / top y, 10 bits per slot
//   shot_pixel         render coordinate lies inside an active shot
module shot_pool #(
    parameter int unsigned NUM_SHOTS       = 4,
    parameter int unsigned SHOT_WIDTH      = 2,
    parameter int unsigned SHOT_HEIGHT     = 8,
    parameter int unsigned SHOT_VELOCITY   = 3,
    parameter int unsigned DIR_UP          = 1,
    parameter int unsigned COOLDOWN_FRAMES = 8,
    parameter int unsigned X_MIN           = 32,
    parameter int unsigned X_MAX           = 607,
    parameter int unsigned Y_MIN           = 36,
    parameter int unsigned Y_MAX           = 451,
    parameter int unsigned Y_TOP_LIMIT     = 40
) (
    input  logic                    s_clk,
    input  logic                    rst_n,
    input  logic                    clk_0,
    input  logic                    pause,
    input  logic                    fire,
    input  logic [9:0]              orig_x,
    input  logic [9:0]              orig_y,
    input  logic [9:0]              pixel_x,
    input  logic [9:0]              pixel_y,
    input  logic [NUM_SHOTS-1:0]    hit_vec,
    output logic                    fire_ack,
    output logic [NUM_SHOTS-1:0]    active_vec,
    output logic [3:0]              active_count,
    output logic [10*NUM_SHOTS-1:0] shot_x_flat,
    output logic [10*NUM_SHOTS-1:0] shot_y_flat,
    output logic                    shot_pixel
);
    localparam int unsigned CW   = 10;
    localparam int unsigned CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam int XLO     = int'(X_MIN);
    localparam int XHI     = int'(X_MAX - SHOT_WIDTH);
    localparam int HALF_W  = int'(SHOT_WIDTH / 2);
    localparam int H       = int'(SHOT_HEIGHT);
    localparam int V       = int'(SHOT_VELOCITY);
    localparam int YLO     = int'(Y_MIN);
    localparam int YHI     = int'(Y_MAX);
    localparam int YTOP    = int'(Y_TOP_LIMIT);
    localparam int YDN_MAX = int'(Y_MAX - SHOT_HEIGHT + 1);

    logic [CW-1:0]        x_q [NUM_SHOTS];
    logic [CW-1:0]        x_d [NUM_SHOTS];
    logic [CW-1:0]        y_q [NUM_SHOTS];
    logic [CW-1:0]        y_d [NUM_SHOTS];
    logic [NUM_SHOTS-1:0] active_q, active_d;
    logic [3:0]           count_q, count_d;
    logic [CD_W-1:0]      cd_q, cd_d;
    logic                 pending_q, pending_d;
    logic                 fire_ack_q, fire_ack_d;

    logic [NUM_SHOTS-1:0] free_v, spawn_oh;
    logic                 do_spawn;
    logic [CW-1:0]        spawn_x, spawn_y;
    int                   sx, sy, yi;
    logic                 in_field;

    // Spawn position, clamped in signed arithmetic so small origins never wrap
    always_comb begin
        sx = int'({22'b0, orig_x}) - HALF_W;
        if (sx < XLO) begin
            sx = XLO;
        end else if (sx > XHI) begin
            sx = XHI;
        end
        if (DIR_UP != 0) begin
            sy = int'({22'b0, orig_y}) - H;
            if (sy < YLO) sy = YLO;
        end else begin
            sy = int'({22'b0, orig_y}) + 1;
            if (sy > YDN_MAX) sy = YDN_MAX;
        end
        spawn_x = CW'(sx);
        spawn_y = CW'(sy);
    end

    // Lowest slot that was free before this edge; same-edge retirements are not reused
    assign free_v   = ~active_q;
    assign spawn_oh = free_v & (~free_v + NUM_SHOTS'(1));
    assign do_spawn = ~pause & clk_0 & (pending_q | fire) & (cd_q == '0) & (|free_v);

    // Next state: hit beats motion, spawn fills a previously free slot
    always_comb begin
        active_d   = active_q;
        x_d        = x_q;
        y_d        = y_q;
        cd_d       = cd_q;
        pending_d  = pending_q;
        fire_ack_d = 1'b0;
        count_d    = '0;
        yi         = 0;
        if (!pause) begin
            pending_d = clk_0 ? 1'b0 : (pending_q | fire);
            for (int i = 0; i < int'(NUM_SHOTS); i++) begin
                yi = int'({22'b0, y_q[i]});
                if (active_q[i] && hit_vec[i]) begin
                    active_d[i] = 1'b0;
                end else if (active_q[i] && clk_0) begin
                    if (DIR_UP != 0) begin
                        if ((yi <= YTOP) || (yi < YLO + V)) active_d[i] = 1'b0;
                        else                                y_d[i]      = CW'(yi - V);
                    end else begin
                        if (yi + H - 1 + V > YHI) active_d[i] = 1'b0;
                        else                      y_d[i]      = CW'(yi + V);
                    end
                end
                if (do_spawn && spawn_oh[i]) begin
                    active_d[i] = 1'b1;
                    x_d[i]      = spawn_x;
                    y_d[i]      = spawn_y;
                end
            end
            if (do_spawn) begin
                cd_d       = CD_W'(COOLDOWN_FRAMES);
                fire_ack_d = 1'b1;
            end else if (clk_0 && cd_q != '0) begin
                cd_d = cd_q - CD_W'(1);
            end
        end
        for (int i = 0; i < int'(NUM_SHOTS); i++) begin
            count_d = count_d + 4'(active_d[i]);
        end
    end

    // State registers
    always_ff @(posedge s_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_SHOTS); i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
            active_q   <= '0;
            count_q    <= '0;
            cd_q       <= '0;
            pending_q  <= 1'b0;
            fire_ack_q <= 1'b0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            active_q   <= active_d;
            count_q    <= count_d;
            cd_q       <= cd_d;
            pending_q  <= pending_d;
            fire_ack_q <= fire_ack_d;
        end
    end

    assign fire_ack     = fire_ack_q;
    assign active_vec   = active_q;
    assign active_count = count_q;

    for (genvar g = 0; g < NUM_SHOTS; g++) begin : g_flat
        assign shot_x_flat[CW*g +: CW] = x_q[g];
        assign shot_y_flat[CW*g +: CW] = y_q[g];
    end

    // Render: pixel inside the play field and inside any active shot box
    always_comb begin
        shot_pixel = 1'b0;
        in_field   = (pixel_x >= CW'(X_MIN)) && (pixel_x <= CW'(X_MAX)) &&
                     (pixel_y >= CW'(Y_MIN)) && (pixel_y <= CW'(Y_MAX));
        for (int i = 0; i < int'(NUM_SHOTS); i++) begin
            if (active_q[i] && in_field &&
                ({1'b0, pixel_x} >= {1'b0, x_q[i]}) &&
                ({1'b0, pixel_x} <= {1'b0, x_q[i]} + 11'(SHOT_WIDTH - 1)) &&
                ({1'b0, pixel_y} >= {1'b0, y_q[i]}) &&
                ({1'b0, pixel_y} <= {1'b0, y_q[i]} + 11'(SHOT_HEIGHT - 1))) begin
                shot_pixel = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_shot_pool.sv
// tb_shot_pool: drives an up-moving and a down-moving shot_pool from shared
// stimulus and compares both against a behavioural slot model every cycle.
module tb_shot_pool;
    logic        s_clk = 1'b0;
    logic        rst_n, clk_0, pause, fire;
    logic [9:0]  orig_x, orig_y, pixel_x, pixel_y;
    logic [3:0]  hit_vec;
    logic        ack_u, ack_d, pix_u, pix_d;
    logic [3:0]  av_u, av_d, cnt_u, cnt_d;
    logic [39:0] xf_u, yf_u, xf_d, yf_d;
    int          total = 0;
    int          bad   = 0;

    always #5 s_clk = ~s_clk;

    shot_pool #(.DIR_UP(1)) dut_up (
        .s_clk(s_clk), .rst_n(rst_n), .clk_0(clk_0), .pause(pause), .fire(fire),
        .orig_x(orig_x), .orig_y(orig_y), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .hit_vec(hit_vec), .fire_ack(ack_u), .active_vec(av_u), .active_count(cnt_u),
        .shot_x_flat(xf_u), .shot_y_flat(yf_u), .shot_pixel(pix_u)
    );

    shot_pool #(.DIR_UP(0)) dut_dn (
        .s_clk(s_clk), .rst_n(rst_n), .clk_0(clk_0), .pause(pause), .fire(fire),
        .orig_x(orig_x), .orig_y(orig_y), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .hit_vec(hit_vec), .fire_ack(ack_d), .active_vec(av_d), .active_count(cnt_d),
        .shot_x_flat(xf_d), .shot_y_flat(yf_d), .shot_pixel(pix_d)
    );

    // Reference model: index 0 = up pool, 1 = down pool
    int m_x   [2][4];
    int m_y   [2][4];
    bit m_act [2][4];
    int m_cd  [2];
    bit m_pend[2];
    bit m_ack [2];

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                m_x[d][i] = 0; m_y[d][i] = 0; m_act[d][i] = 0;
            end
            m_cd[d] = 0; m_pend[d] = 0; m_ack[d] = 0;
        end
    endfunction

    function automatic void model_step(int d);
        int free_slot;
        bit want;
        int nx, ny;
        free_slot = -1;
        m_ack[d] = 0;
        if (pause) return;
        for (int i = 3; i >= 0; i--) if (!m_act[d][i]) free_slot = i;
        want = m_pend[d] || fire;
        for (int i = 0; i < 4; i++) begin
            if (m_act[d][i]) begin
                if (hit_vec[i]) m_act[d][i] = 0;
                else if (clk_0) begin
                    if (d == 0) begin
                        if (m_y[d][i] <= 40 || m_y[d][i] < 36 + 3) m_act[d][i] = 0;
                        else m_y[d][i] = m_y[d][i] - 3;
                    end else begin
                        if (m_y[d][i] + 8 - 1 + 3 > 451) m_act[d][i] = 0;
                        else m_y[d][i] = m_y[d][i] + 3;
                    end
                end
            end
        end
        if (clk_0) begin
            if (want && m_cd[d] == 0 && free_slot >= 0) begin
                nx = int'(orig_x) - 1;
                if (nx < 32) nx = 32;
                if (nx > 605) nx = 605;
                if (d == 0) begin
                    ny = int'(orig_y) - 8;
                    if (ny < 36) ny = 36;
                end else begin
                    ny = int'(orig_y) + 1;
                    if (ny > 444) ny = 444;
                end
                m_act[d][free_slot] = 1;
                m_x[d][free_slot] = nx;
                m_y[d][free_slot] = ny;
                m_cd[d] = 8;
                m_ack[d] = 1;
            end else if (m_cd[d] > 0) begin
                m_cd[d] = m_cd[d] - 1;
            end
            m_pend[d] = 0;
        end else if (fire) begin
            m_pend[d] = 1;
        end
    endfunction

    function automatic bit model_pix(int d);
        int px, py;
        bit hit;
        px = int'(pixel_x);
        py = int'(pixel_y);
        hit = 0;
        if (px >= 32 && px <= 607 && py >= 36 && py <= 451)
            for (int i = 0; i < 4; i++)
                if (m_act[d][i] && px >= m_x[d][i] && px <= m_x[d][i] + 1 &&
                    py >= m_y[d][i] && py <= m_y[d][i] + 7) hit = 1;
        return hit;
    endfunction

    function automatic logic [39:0] exp_flat(int d, bit want_y);
        logic [39:0] f;
        f = '0;
        for (int i = 0; i < 4; i++) f[10*i +: 10] = 10'(want_y ? m_y[d][i] : m_x[d][i]);
        return f;
    endfunction

    function automatic logic [3:0] exp_av(int d);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_act[d][i];
        return v;
    endfunction

    function automatic logic [3:0] exp_cnt(int d);
        int c;
        c = 0;
        for (int i = 0; i < 4; i++) c += int'(m_act[d][i]);
        return 4'(c);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ack_up",  64'(ack_u), 64'(m_ack[0]));
        chk("ack_dn",  64'(ack_d), 64'(m_ack[1]));
        chk("av_up",   64'(av_u),  64'(exp_av(0)));
        chk("av_dn",   64'(av_d),  64'(exp_av(1)));
        chk("cnt_up",  64'(cnt_u), 64'(exp_cnt(0)));
        chk("cnt_dn",  64'(cnt_d), 64'(exp_cnt(1)));
        chk("x_up",    64'(xf_u),  64'(exp_flat(0, 1'b0)));
        chk("x_dn",    64'(xf_d),  64'(exp_flat(1, 1'b0)));
        chk("y_up",    64'(yf_u),  64'(exp_flat(0, 1'b1)));
        chk("y_dn",    64'(yf_d),  64'(exp_flat(1, 1'b1)));
        chk("pix_up",  64'(pix_u), 64'(model_pix(0)));
        chk("pix_dn",  64'(pix_d), 64'(model_pix(1)));
    endtask

    // One s_clk cycle with the current inputs; clk_0 set for this cycle only
    task automatic cyc(input bit tk);
        clk_0 = tk;
        model_step(0);
        model_step(1);
        @(posedge s_clk);
        #1;
        check_all();
        clk_0 = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        fire = 0; pause = 0; hit_vec = '0; clk_0 = 0;
        chk("rst_av_up",  64'(av_u),  64'd0);
        chk("rst_av_dn",  64'(av_d),  64'd0);
        chk("rst_cnt_up", 64'(cnt_u), 64'd0);
        chk("rst_cnt_dn", 64'(cnt_d), 64'd0);
        chk("rst_ack_up", 64'(ack_u), 64'd0);
        chk("rst_x_up",   64'(xf_u),  64'd0);
        chk("rst_y_dn",   64'(yf_d),  64'd0);
        chk("rst_pix_up", 64'(pix_u), 64'd0);
        @(posedge s_clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic pix_chk(input string tag, input int px, input int py, input bit exp);
        pixel_x = 10'(px);
        pixel_y = 10'(py);
        #1;
        chk(tag, 64'(pix_u), 64'(exp));
        chk({tag, "_dn"}, 64'(pix_d), 64'(model_pix(1)));
    endtask

    logic [63:0] ack_mask, exp_mask;
    logic [3:0]  snap_av;
    logic [39:0] snap_x, snap_y;

    initial begin
        rst_n = 0; clk_0 = 0; pause = 0; fire = 0; hit_vec = '0;
        orig_x = '0; orig_y = '0; pixel_x = '0; pixel_y = '0;
        model_reset();
        @(posedge s_clk);
        #1;
        do_reset();

        // Basic spawn via pending, then motion and rendering
        orig_x = 10'd100; orig_y = 10'd400; fire = 1;
        cyc(0);
        fire = 0;
        cyc(1);
        chk("b_ack",  64'(ack_u), 64'd1);
        chk("b_x0",   64'(xf_u[9:0]), 64'd99);
        chk("b_y0",   64'(yf_u[9:0]), 64'd392);
        chk("b_av",   64'(av_u), 64'd1);
        cyc(0);
        chk("b_ack_one_cycle", 64'(ack_u), 64'd0);
        cyc(1);
        chk("b_y0_move", 64'(yf_u[9:0]), 64'd389);
        pix_chk("b_pix_tl",    99, 389, 1'b1);
        pix_chk("b_pix_br",   100, 396, 1'b1);
        pix_chk("b_pix_right", 101, 389, 1'b0);
        pix_chk("b_pix_below",  99, 397, 1'b0);

        // Held fire: cooldown spacing, full pool, slot reuse after hit
        do_reset();
        orig_x = 10'd100; orig_y = 10'd400; fire = 1;
        ack_mask = '0;
        for (int t = 0; t < 37; t++) begin
            cyc(0);
            cyc(1);
            ack_mask[t] = ack_u;
        end
        exp_mask = '0;
        exp_mask[0] = 1'b1; exp_mask[9] = 1'b1; exp_mask[18] = 1'b1; exp_mask[27] = 1'b1;
        chk("c_ack_ticks", ack_mask, exp_mask);
        chk("c_full",      64'(av_u), 64'hF);
        chk("c_full_cnt",  64'(cnt_u), 64'd4);
        hit_vec = 4'b0010;
        cyc(0);
        hit_vec = '0;
        chk("c_hit_clear", 64'(av_u), 64'hD);
        cyc(1);
        chk("c_reuse_ack", 64'(ack_u), 64'd1);
        chk("c_reuse_av",  64'(av_u), 64'hF);
        chk("c_reuse_y1",  64'(yf_u[19:10]), 64'd392);

        // Pause freezes everything despite fire, hit and ticks
        snap_av = exp_av(0); snap_x = exp_flat(0, 1'b0); snap_y = exp_flat(0, 1'b1);
        pause = 1; hit_vec = 4'hF; fire = 1;
        for (int t = 0; t < 5; t++) begin
            cyc(0);
            cyc(1);
            chk("d_no_ack", 64'(ack_u), 64'd0);
        end
        chk("d_av_held", 64'(av_u), 64'(snap_av));
        chk("d_x_held",  64'(xf_u), 64'(snap_x));
        chk("d_y_held",  64'(yf_u), 64'(snap_y));
        pause = 0; hit_vec = '0; fire = 0;
        cyc(0);

        // Spawn clamping
        do_reset();
        orig_x = 10'd0; orig_y = 10'd450; fire = 1;
        cyc(1);
        fire = 0;
        chk("e_x_lo",    64'(xf_u[9:0]), 64'd32);
        chk("e_up_y",    64'(yf_u[9:0]), 64'd442);
        chk("e_dn_x_lo", 64'(xf_d[9:0]), 64'd32);
        chk("e_dn_y_hi", 64'(yf_d[9:0]), 64'd444);
        do_reset();
        orig_x = 10'd620; orig_y = 10'd200; fire = 1;
        cyc(1);
        fire = 0;
        chk("e_x_hi",    64'(xf_u[9:0]), 64'd605);
        chk("e_dn_y",    64'(yf_d[9:0]), 64'd201);

        // Up-shot retirement near the top, and hit on a tick
        do_reset();
        orig_x = 10'd200; orig_y = 10'd50; fire = 1;
        cyc(1);
        fire = 0;
        chk("f_y42",    64'(yf_u[9:0]), 64'd42);
        cyc(1);
        chk("f_y39",    64'(yf_u[9:0]), 64'd39);
        cyc(1);
        chk("f_retire", 64'(av_u), 64'd0);
        do_reset();
        fire = 1;
        cyc(1);
        fire = 0;
        chk("f_spawn", 64'(av_u), 64'd1);
        hit_vec = 4'b0001;
        cyc(1);
        hit_vec = '0;
        chk("f_hit_tick", 64'(av_u), 64'd0);

        // Reset mid-flight with three live shots
        do_reset();
        orig_x = 10'd300; orig_y = 10'd420; fire = 1;
        for (int t = 0; t < 19; t++) cyc(1);
        fire = 0;
        chk("g_three_live", 64'(av_u), 64'h7);
        chk("g_three_cnt",  64'(cnt_u), 64'd3);
        do_reset();

        // Randomised traffic against the model
        for (int n = 0; n < 2500; n++) begin
            int d, k;
            fire    = ($urandom_range(0, 2) == 0);
            pause   = ($urandom_range(0, 15) == 0);
            hit_vec = 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom);
            orig_x  = 10'($urandom);
            orig_y  = 10'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                d = int'($urandom_range(0, 1));
                k = int'($urandom_range(0, 3));
                pixel_x = 10'(m_x[d][k] + int'($urandom_range(0, 2)));
                pixel_y = 10'(m_y[d][k] - 1 + int'($urandom_range(0, 9)));
            end else begin
                pixel_x = 10'($urandom);
                pixel_y = 10'($urandom);
            end
            if ($urandom_range(0, 799) == 0) do_reset();
            else cyc($urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
